// File: rtl/uart_rx.sv
// 8N1 UART receiver with a mid-bit sampling FSM, sticky error flags and a
// single-entry output register cleared by a core-side strobe.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx_in,
   input  logic       rx_clr,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_overrun,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

   state_t      state;
   logic        sync1;
   logic        rx_s;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        stop_ok;
   logic        load;
   logic        ferr_set;

   // stop_ok delays the byte load by one clock after a good stop sample
   assign load     = (state == STOP) && stop_ok;
   assign ferr_set = (state == STOP) && !stop_ok && (cnt == BIT_LAST) && !rx_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1        <= 1'b1;
         rx_s         <= 1'b1;
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         shift        <= '0;
         stop_ok      <= 1'b0;
         rx_busy      <= 1'b0;
         rx_data      <= 8'h00;
         rx_valid     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         sync1 <= uart_rx_in;
         rx_s  <= sync1;

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state   <= START;
                  cnt     <= '0;
                  bit_idx <= '0;
                  rx_busy <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt            <= '0;
                  shift[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            STOP: begin
               if (stop_ok) begin
                  stop_ok <= 1'b0;
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end else if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     stop_ok <= 1'b1;
                  end else begin
                     state <= BREAK;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase

         // A load always wins over rx_clr; a clear in the same cycle means the
         // previous byte was consumed, so no overrun is reported.
         if (load) begin
            rx_data    <= shift;
            rx_valid   <= 1'b1;
            rx_overrun <= !rx_clr && (rx_overrun || rx_valid);
         end else if (rx_clr) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
         end

         if (ferr_set) begin
            rx_frame_err <= 1'b1;
         end else if (rx_clr) begin
            rx_frame_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 8 clocks per bit: the stimulus queues the
// expected flag/data state for each receive event, a monitor checks it.
module tb_uart_rx;

   localparam int CPB = 8;
   localparam int LAT = 80;   // drive time -> edge where rx_valid rises

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rx_in;
   logic       rx_clr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_overrun;
   logic       rx_frame_err;
   logic       rx_busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic       ov;
      logic       fe;
      int         at;
   } exp_t;

   exp_t q[$];
   exp_t e;
   logic pv = 1'b0, po = 1'b0, pf = 1'b0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .rst          (rst),
      .uart_rx_in   (uart_rx_in),
      .rx_clr       (rx_clr),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err),
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // An event is any rising flag; each one must match the next queued entry.
   always @(negedge clk) begin
      if (rst) begin
         if ((rx_valid && !pv) || (rx_overrun && !po) || (rx_frame_err && !pf)) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: actual v=%b ov=%b fe=%b data=%h required none",
                        rx_valid, rx_overrun, rx_frame_err, rx_data);
            end else begin
               e = q.pop_front();
               check("ev_data", 32'(rx_data), 32'(e.data));
               check("ev_valid", 32'(rx_valid), 32'(e.valid));
               check("ev_overrun", 32'(rx_overrun), 32'(e.ov));
               check("ev_frame_err", 32'(rx_frame_err), 32'(e.fe));
               if (e.at != 0) check("ev_latency", 32'(cyc), 32'(e.at));
               $display("rx event cyc=%0d data=%h v=%b ov=%b fe=%b",
                        cyc, rx_data, rx_valid, rx_overrun, rx_frame_err);
            end
         end
         pv = rx_valid;
         po = rx_overrun;
         pf = rx_frame_err;
      end else begin
         pv = 1'b0;
         po = 1'b0;
         pf = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_ev(input logic [7:0] d, input logic v, input logic ov,
                            input logic fe, input bit timed);
      exp_t x;
      x.data  = d;
      x.valid = v;
      x.ov    = ov;
      x.fe    = fe;
      x.at    = timed ? cyc + LAT : 0;
      q.push_back(x);
   endtask

   task automatic send(input logic [7:0] d, input logic stop);
      uart_rx_in = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx_in = d[i];
         tick(CPB);
      end
      uart_rx_in = stop;
      tick(CPB);
   endtask

   task automatic pulse_clr();
      rx_clr = 1'b1;
      tick(1);
      rx_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b0;
      uart_rx_in = 1'b1;
      rx_clr     = 1'b0;
      tick(3);
      check("rst_data", 32'(rx_data), 32'h00);
      check("rst_valid", 32'(rx_valid), 32'd0);
      check("rst_overrun", 32'(rx_overrun), 32'd0);
      check("rst_frame_err", 32'(rx_frame_err), 32'd0);
      check("rst_busy", 32'(rx_busy), 32'd0);
      rst = 1'b1;
      tick(3);

      // basic byte with exact latency
      expect_ev(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      send(8'hA5, 1'b1);
      tick(2);
      check("a5_busy_after", 32'(rx_busy), 32'd0);
      pulse_clr();
      check("a5_clr_valid", 32'(rx_valid), 32'd0);
      check("a5_clr_data", 32'(rx_data), 32'hA5);

      // back-to-back bytes without clearing -> overrun
      expect_ev(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
      send(8'h3C, 1'b1);
      expect_ev(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
      send(8'hC3, 1'b1);
      tick(2);
      pulse_clr();
      check("ov_clr_valid", 32'(rx_valid), 32'd0);
      check("ov_clr_overrun", 32'(rx_overrun), 32'd0);
      check("ov_clr_frame_err", 32'(rx_frame_err), 32'd0);
      check("ov_clr_data", 32'(rx_data), 32'hC3);

      // 2-clock glitch: false start
      uart_rx_in = 1'b0;
      tick(2);
      uart_rx_in = 1'b1;
      tick(2);
      check("glitch_busy_start", 32'(rx_busy), 32'd1);
      tick(8);
      check("glitch_busy_end", 32'(rx_busy), 32'd0);
      check("glitch_valid", 32'(rx_valid), 32'd0);
      check("glitch_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);

      // framing error followed by a long break
      expect_ev(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h55, 1'b0);
      tick(19 * CPB);
      check("brk_busy", 32'(rx_busy), 32'd1);
      check("brk_frame_err", 32'(rx_frame_err), 32'd1);
      check("brk_valid", 32'(rx_valid), 32'd0);
      uart_rx_in = 1'b1;
      tick(4);
      check("brk_busy_end", 32'(rx_busy), 32'd0);
      pulse_clr();
      check("brk_clr_frame_err", 32'(rx_frame_err), 32'd0);
      tick(CPB);
      expect_ev(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
      send(8'h0F, 1'b1);
      tick(2);

      // reset during bit 4 of 8'hFF (rx_valid is still high from 8'h0F)
      uart_rx_in = 1'b0;
      tick(CPB);
      uart_rx_in = 1'b1;
      tick(4 * CPB + CPB / 2);
      rst = 1'b0;
      tick(1);
      check("mid_rst_busy", 32'(rx_busy), 32'd0);
      check("mid_rst_valid", 32'(rx_valid), 32'd0);
      check("mid_rst_data", 32'(rx_data), 32'h00);
      tick(2);
      rst = 1'b1;
      tick(3 * CPB);
      check("post_rst_busy", 32'(rx_busy), 32'd0);
      check("post_rst_valid", 32'(rx_valid), 32'd0);
      expect_ev(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
      send(8'h81, 1'b1);
      tick(2);

      // rx_clr on the load edge: new byte kept, no overrun
      fork
         send(8'h7E, 1'b1);
         begin
            tick(LAT - 1);
            rx_clr = 1'b1;
            tick(1);
            rx_clr = 1'b0;
         end
      join
      tick(2);
      check("clr_load_valid", 32'(rx_valid), 32'd1);
      check("clr_load_data", 32'(rx_data), 32'h7E);
      check("clr_load_overrun", 32'(rx_overrun), 32'd0);

      tick(4);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
